// File: rtl/multicycle_control.sv
// Multicycle control unit for the single-issue RISC-V datapath.
// Sequences IF/ID/EX/MEM/WB and drives every datapath strobe.
module multicycle_control #(
   parameter bit SKIP_MEM = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic [3:0]  ALUCtrl,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        loadPC
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_NOP,
      C_R,
      C_I,
      C_LOAD,
      C_STORE,
      C_BR
   } cls_t;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0111;
   localparam logic [3:0] A_SRL = 4'b1000;
   localparam logic [3:0] A_SLL = 4'b1001;
   localparam logic [3:0] A_SRA = 4'b1010;
   localparam logic [3:0] A_XOR = 4'b1101;

   state_t     state;
   logic [6:0] op_q;
   logic [2:0] f3_q;
   cls_t       cls_d;
   cls_t       cls_q;
   logic [3:0] alu_d;
   logic       src_d;
   logic       unused_bits;

   function automatic cls_t classify(
      input logic [6:0] op,
      input logic [2:0] f3
   );
      cls_t c;
      c = C_NOP;
      if (op == 7'b0110011)
         c = C_R;
      else if (op == 7'b0010011)
         c = C_I;
      else if (op == 7'b0000011 && f3 == 3'b010)
         c = C_LOAD;
      else if (op == 7'b0100011 && f3 == 3'b010)
         c = C_STORE;
      else if (op == 7'b1100011 && f3 == 3'b000)
         c = C_BR;
      return c;
   endfunction

   function automatic logic [3:0] alu_code(
      input cls_t       c,
      input logic [2:0] f3,
      input logic       f7
   );
      logic [3:0] a;
      a = A_ADD;
      if (c == C_R || c == C_I) begin
         case (f3)
            3'b000:  a = (c == C_R && f7) ? A_SUB : A_ADD;
            3'b001:  a = A_SLL;
            3'b010:  a = A_SLT;
            3'b100:  a = A_XOR;
            3'b101:  a = f7 ? A_SRA : A_SRL;
            3'b110:  a = A_OR;
            3'b111:  a = A_AND;
            default: a = A_ADD;
         endcase
      end else if (c == C_BR) begin
         a = A_SUB;
      end
      return a;
   endfunction

   // decode of the live word (used at ID->EX) and of the latched fields
   always_comb begin
      cls_d = classify(instr[6:0], instr[14:12]);
      alu_d = alu_code(cls_d, instr[14:12], instr[30]);
      src_d = (cls_d == C_I) || (cls_d == C_LOAD) || (cls_d == C_STORE);
      cls_q = classify(op_q, f3_q);
   end

   // operand/immediate bits are the datapath's business, not ours
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // branch outcome is only honoured while in write-back
   assign PCSrc = (state == S_WB) && (cls_q == C_BR) && Zero;

   // state sequencing with registered strobes for the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IF;
         op_q     <= 7'd0;
         f3_q     <= 3'd0;
         ALUSrc   <= 1'b0;
         ALUCtrl  <= 4'd0;
         RegWrite <= 1'b0;
         MemToReg <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         loadPC   <= 1'b0;
      end else begin
         RegWrite <= 1'b0;
         MemToReg <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         loadPC   <= 1'b0;
         case (state)
            S_IF: state <= S_ID;
            S_ID: begin
               state   <= S_EX;
               op_q    <= instr[6:0];
               f3_q    <= instr[14:12];
               ALUCtrl <= alu_d;
               ALUSrc  <= src_d;
            end
            S_EX: begin
               if (SKIP_MEM &&
                   cls_q != C_LOAD &&
                   cls_q != C_STORE) begin
                  state    <= S_WB;
                  loadPC   <= 1'b1;
                  RegWrite <= (cls_q == C_R) || (cls_q == C_I);
               end else begin
                  state    <= S_MEM;
                  MemRead  <= (cls_q == C_LOAD);
                  MemWrite <= (cls_q == C_STORE);
               end
            end
            S_MEM: begin
               state    <= S_WB;
               loadPC   <= 1'b1;
               RegWrite <= (cls_q == C_R) ||
                           (cls_q == C_I) ||
                           (cls_q == C_LOAD);
               MemToReg <= (cls_q == C_LOAD);
            end
            S_WB:    state <= S_IF;
            default: state <= S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: hand vectors plus random instructions
// checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        zero;

   logic        pcs0, src0, rw0, m2r0, mrd0, mwr0, lpc0;
   logic [3:0]  alu0;
   logic        pcs1, src1, rw1, m2r1, mrd1, mwr1, lpc1;
   logic [3:0]  alu1;

   logic [10:0] o0, o1;

   int passed;
   int total;

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      logic        skip;
      int          len;
      logic [3:0]  alu;
      logic        src;
      logic        rw;
      logic        m2r;
      logic        mrd;
      logic        mwr;
      logic        pcs;
   } vec_t;

   vec_t tbl[$];

   localparam logic [31:0] ALU_TAB =
      {4'h0, 4'h1, 4'h8, 4'hD, 4'h2, 4'h7, 4'h9, 4'h2};
   localparam logic [31:0] I_ADD = 32'h002081B3;

   always #5 clk = ~clk;

   multicycle_control #(.SKIP_MEM(1'b0)) dut0 (
      .clk(clk), .rst(rst), .instr(instr), .Zero(zero),
      .PCSrc(pcs0), .ALUSrc(src0), .ALUCtrl(alu0),
      .RegWrite(rw0), .MemToReg(m2r0), .MemRead(mrd0),
      .MemWrite(mwr0), .loadPC(lpc0)
   );

   multicycle_control #(.SKIP_MEM(1'b1)) dut1 (
      .clk(clk), .rst(rst), .instr(instr), .Zero(zero),
      .PCSrc(pcs1), .ALUSrc(src1), .ALUCtrl(alu1),
      .RegWrite(rw1), .MemToReg(m2r1), .MemRead(mrd1),
      .MemWrite(mwr1), .loadPC(lpc1)
   );

   assign o0 = {pcs0, src0, alu0, rw0, m2r0, mrd0, mwr0, lpc0};
   assign o1 = {pcs1, src1, alu1, rw1, m2r1, mrd1, mwr1, lpc1};

   function automatic vec_t mk(
      input logic [31:0] i, input logic z, input logic s,
      input int l, input logic [3:0] a, input logic sr,
      input logic w, input logic m, input logic rd,
      input logic wr, input logic p
   );
      vec_t v;
      v.instr = i; v.zero = z; v.skip = s; v.len = l;
      v.alu = a; v.src = sr; v.rw = w; v.m2r = m;
      v.mrd = rd; v.mwr = wr; v.pcs = p;
      return v;
   endfunction

   // instruction-level reference: what the instruction must do overall
   function automatic vec_t model(
      input logic [31:0] i, input logic z, input logic s
   );
      logic [6:0] op;
      logic [2:0] f3;
      logic       r, im, ld, st, br;
      logic [3:0] a;
      op = i[6:0];
      f3 = i[14:12];
      r  = (op == 7'h33);
      im = (op == 7'h13);
      ld = (op == 7'h03) && (f3 == 3'd2);
      st = (op == 7'h23) && (f3 == 3'd2);
      br = (op == 7'h63) && (f3 == 3'd0);
      a  = 4'h2;
      if (r || im) begin
         a = ALU_TAB[f3*4 +: 4];
         if (i[30] && f3 == 3'd5) a = 4'hA;
         if (i[30] && f3 == 3'd0 && r) a = 4'h6;
      end else if (br) begin
         a = 4'h6;
      end
      return mk(i, z, s, (s && !(ld || st)) ? 4 : 5, a,
                im | ld | st, r | im | ld, ld, ld, st, br & z);
   endfunction

   function automatic logic [10:0] expect_at(input vec_t v, input int k);
      logic [10:0] e;
      e = '0;
      if (k >= 2) begin
         e[9]   = v.src;
         e[8:5] = v.alu;
      end
      if (k == v.len - 1) begin
         e[10] = v.pcs;
         e[4]  = v.rw;
         e[3]  = v.m2r;
         e[0]  = 1'b1;
      end else if (k == 3) begin
         e[2] = v.mrd;
         e[1] = v.mwr;
      end
      return e;
   endfunction

   task automatic check(
      input string nm, input logic [10:0] act,
      input logic [10:0] exp, input logic [10:0] mask
   );
      total++;
      if ((act & mask) === (exp & mask))
         passed++;
      else
         $display("FAIL %s got=%h want=%h mask=%h t=%0t",
                  nm, act, exp, mask, $time);
   endtask

   // runs one instruction starting in IF; abort_k stops after that cycle
   task automatic run(input vec_t v, input bit scramble, input int abort_k);
      logic [10:0] act;
      for (int k = 0; k < v.len; k++) begin
         if (k == 0) instr = v.instr;
         else if (scramble && k >= 2) instr = $urandom;
         zero = (k == v.len - 1) ? v.zero : 1'($urandom_range(0, 1));
         #1;
         act = v.skip ? o1 : o0;
         check($sformatf("instr_%h_c%0d", v.instr, k), act,
               expect_at(v, k), (k < 2) ? 11'h41F : 11'h7FF);
         if (k == abort_k) return;
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst   = 1'b0;
      instr = I_ADD;
      zero  = 1'b0;
      repeat (cycles) @(negedge clk);
      #1;
      check("reset_d0", o0, 11'h0, 11'h7FF);
      check("reset_d1", o1, 11'h0, 11'h7FF);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] ri;
      logic [6:0]  ops [6];
      passed = 0;
      total  = 0;
      rst    = 1'b0;
      instr  = I_ADD;
      zero   = 1'b0;
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
      ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h7F;

      //            instr        z  s  len alu    src rw m2r rd wr pcs
      tbl.push_back(mk(I_ADD,        0, 0, 5, 4'h2, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h402081B3, 0, 0, 5, 4'h6, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h4020D093, 0, 0, 5, 4'hA, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h40008093, 0, 0, 5, 4'h2, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h0080A283, 0, 0, 5, 4'h2, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(32'h0050A223, 0, 0, 5, 4'h2, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(32'h00208463, 1, 0, 5, 4'h6, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(32'h00208463, 0, 0, 5, 4'h6, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'h0000007F, 1, 0, 5, 4'h2, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'h0020C1B3, 0, 0, 5, 4'hD, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(I_ADD,        0, 1, 4, 4'h2, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h0080A283, 0, 1, 5, 4'h2, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(32'h0050A223, 0, 1, 5, 4'h2, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(32'h00208463, 1, 1, 4, 4'h6, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(32'h4020D1B3, 0, 1, 4, 4'hA, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(32'h0000007F, 0, 1, 4, 4'h2, 0, 0, 0, 0, 0, 0));

      for (int s = 0; s < 2; s++) begin
         do_reset(3);
         foreach (tbl[i])
            if (tbl[i].skip == 1'(s)) run(tbl[i], 1'b0, -1);

         if (s == 0) begin
            run(model(I_ADD, 1'b0, 1'b0), 1'b0, 2);
            rst = 1'b0;
            #1;
            check("rst_in_ex", o0, 11'h0, 11'h7FF);
            @(negedge clk);
            #1;
            check("rst_hold", o0, 11'h0, 11'h7FF);
            rst = 1'b1;
            run(model(32'h0080A283, 1'b0, 1'b0), 1'b0, -1);
         end

         repeat (150) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 5)];
            if ((ri[6:0] == 7'h33 || ri[6:0] == 7'h13) &&
                ri[14:12] == 3'd3)
               ri[14:12] = 3'd0;
            run(model(ri, 1'($urandom_range(0, 1)), 1'(s)), 1'b1, -1);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the single-issue RISC-V datapath. It is the producer of every control strobe that the datapath consumes.
- It decodes the 32-bit instruction word and sequences each instruction through a multicycle FSM: IF, ID, EX, MEM, WB.
- It drives PC load/select, ALU operand select, ALU operation, register write-back and data-memory read/write.
- It also consumes the ALU Zero flag to resolve BEQ.

Parameters:
- SKIP_MEM, 0, when 1 non-load/store instructions go EX->WB directly (4 cycles); when 0 every instruction takes 5 cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- instr  input  32  instruction word from instruction ROM, valid from IF through WB
- Zero  input  1  ALU zero flag from datapath
- PCSrc  output  1  1 = PC <= PC + branch offset, 0 = PC <= PC + 4
- ALUSrc  output  1  1 = ALU op2 is immediate, 0 = rs2
- ALUCtrl  output  4  ALU operation code
- RegWrite  output  1  register file write enable
- MemToReg  output  1  1 = write-back from dReadData, 0 = from ALU result
- MemRead  output  1  data RAM read strobe
- MemWrite  output  1  data RAM write strobe
- loadPC  output  1  PC update strobe

Behaviour:
- State register, 3 bits: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Transitions: IF->ID->EX->MEM->WB->IF. With SKIP_MEM=1 and a non-load/store class, EX->WB. Undefined encodings 5-7 -> IF.
- Reset: rst low forces, asynchronously, state=IF, latched decode=NOP class, and all outputs 0, including ALUCtrl=0000. Reset mid-instruction abandons that instruction: no write, no PC update. First IF occurs on the first rising edge after rst rises.
- Decode latch: on the ID->EX edge, capture opcode instr[6:0], funct3 instr[14:12] and funct7[5] instr[30]. All EX/MEM/WB outputs derive from the latched fields only, so changes on instr after ID have no effect.
- Classes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011 (funct3 010)
  - STORE = 0100011 (funct3 010)
  - BRANCH = 1100011 (funct3 000, BEQ)
  - Any other opcode/funct3 = NOP: no RegWrite, no MemRead/MemWrite, PC+4.
- ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - R: funct3 000 -> ADD, or SUB if funct7[5]=1; 001 SLL; 010 SLT; 100 XOR; 101 SRL, or SRA if funct7[5]=1; 110 OR; 111 AND.
  - I: same mapping, except funct3 000 is always ADD. funct7[5] selects SRAI only for funct3 101.
  - LOAD/STORE: ADD. BRANCH: SUB. NOP: ADD.
- ALUCtrl and ALUSrc are held from EX through WB. ALUSrc=1 for I, LOAD and STORE; 0 otherwise.
- MEM state:
  - MemRead=1 only for LOAD, MemWrite=1 only for STORE, each exactly one cycle.
  - Other classes pass through MEM with all strobes 0.
- WB state, single cycle:
  - loadPC=1 for every class, including NOP.
  - RegWrite=1 for R, I and LOAD.
  - MemToReg=1 for LOAD only.
  - PCSrc is combinational: BRANCH and Zero, sampled in WB only. Zero toggling outside WB has no effect.
- Outside the states listed above, the strobes RegWrite, MemRead, MemWrite, loadPC and PCSrc are 0. At most one of RegWrite and MemWrite is high in any cycle.
- Latency: instr must be valid by ID. Results commit on the WB->IF edge. Next IF begins the cycle after WB.

Test Plan:
- Reset: hold rst=0 for 3 cycles with instr=0x002081B3 -> all outputs 0 and state IF. Release -> ID one cycle later. Assert rst=0 during EX -> outputs 0 immediately and no loadPC pulse.
- ADD x3,x1,x2 (0x002081B3) -> ALUCtrl=0010 and ALUSrc=0 from EX. Exactly one WB cycle with RegWrite=1, MemToReg=0, loadPC=1. Total 5 cycles.
- SUB (0x402081B3) -> ALUCtrl=0110. SRAI x1,x1,2 (0x4020D093) -> ALUCtrl=1010, ALUSrc=1. ADDI with instr[30]=1 (0x40008093) -> ALUCtrl=0010.
- LW x5,8(x1) (0x0080A283) -> MemRead=1 in MEM only, then RegWrite=1 with MemToReg=1 in WB.
- SW x5,4(x1) (0x0050A223) -> MemWrite=1 in MEM only, RegWrite never asserted.
- BEQ (0x00208463): Zero=1 in WB -> PCSrc=1, loadPC=1. Zero=0 -> PCSrc=0. With SKIP_MEM=1, ADD takes 4 cycles while LW still takes 5. Undefined opcode 0x0000007F -> only loadPC in WB.
